// File: rtl/tinychip_pkg.sv
// tinychip_pkg
//   Shared types and constants for the fetch stage.
//   fetch_state_t      : fetch FSM state encoding (IDLE, RUN, HALTED)
//   HALT_INSTR_DEFAULT : instruction word that ends a program
package tinychip_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [8:0] HALT_INSTR_DEFAULT = 9'h1FF;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// branch_lut
//   DEPTH x W register file holding branch targets (or signed offsets).
//   One synchronous write port, one asynchronous read port; a read of an
//   index being written in the same cycle returns the old contents.
//   Ports:
//     clk, reset   : clock, async active-high reset (all entries -> 0)
//     we/waddr/wdata : write port
//     raddr/rdata  : combinational read port
module branch_lut #(
  parameter int DEPTH = 32,
  parameter int W     = 10,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage: owns the program counter, addresses the
//   instruction memory, hands the fetched word to the controller, resolves
//   taken branches through a writable LUT and flags the halt instruction.
//   Ports:
//     clk, reset          : clock, async active-high reset
//     start               : begin a run at pc=0 (honoured in IDLE/HALTED)
//     stall               : controller back-pressure, freezes pc
//     branch_taken/idx    : redirect pc through lut[branch_idx]
//     lut_we/waddr/wdata  : LUT write port (usable in any state)
//     imem_addr/imem_data : instruction memory interface (combinational read)
//     instr/instr_valid   : fetched word to the controller
//     pc, done            : current program counter, program halted
//   Build option:
//     RELATIVE_BRANCH_EN  : when defined, LUT entries are signed offsets added
//                           to pc; otherwise they are absolute targets.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | after reset, waiting for start; pc held, no valid instr
//   RUN    | fetching; pc advances by increment or branch unless stalled
//   HALTED | halt word seen; done=1, pc held on halt address until start
module fetch_unit
  import tinychip_pkg::*;
#(
  parameter int                 PC_W       = 10,
  parameter int                 INSTR_W    = 9,
  parameter int                 LUT_DEPTH  = 32,
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(HALT_INSTR_DEFAULT),
  localparam int                IDX_W      = $clog2(LUT_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [IDX_W-1:0]   branch_idx,
  input  logic               lut_we,
  input  logic [IDX_W-1:0]   lut_waddr,
  input  logic [PC_W-1:0]    lut_wdata,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               done
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] lut_rdata;
  logic [PC_W-1:0] target;

  branch_lut #(
    .DEPTH (LUT_DEPTH),
    .W     (PC_W)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (branch_idx),
    .rdata (lut_rdata)
  );

`ifdef RELATIVE_BRANCH_EN
  // Same-width two's-complement add gives the signed offset with wrap-around.
  assign target = pc_q + lut_rdata;
`else
  assign target = lut_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Priority in RUN: stall > halt > branch > increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (imem_data == HALT_INSTR) state_d = HALTED;
          else if (branch_taken)       pc_d    = target;
          else                         pc_d    = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_comb begin
    instr_valid = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      RUN:     instr_valid = !stall;
      HALTED:  done        = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = imem_data;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int DEPTH   = 32;
  localparam int IDX_W   = 5;
  localparam int NPC     = 1 << PC_W;
  localparam int HALT    = 'h1FF;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0, stall = 1'b0, branch_taken = 1'b0, lut_we = 1'b0;
  logic [IDX_W-1:0]   branch_idx = '0, lut_waddr = '0;
  logic [PC_W-1:0]    lut_wdata = '0;
  logic [PC_W-1:0]    imem_addr, pc;
  logic [INSTR_W-1:0] imem_data, instr;
  logic               instr_valid, done;

  logic [INSTR_W-1:0] imem [NPC];
  assign imem_data = imem[imem_addr];

  fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_idx(branch_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  int m_mode = 0;
  int m_pc   = 0;
  int m_lut [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    for (int i = 0; i < DEPTH; i++) m_lut[i] = 0;
  endtask

  function automatic int model_target(input int idx);
`ifdef RELATIVE_BRANCH_EN
    return (m_pc + m_lut[idx]) % NPC;
`else
    return m_lut[idx];
`endif
  endfunction

  // One clock cycle: drive inputs after the falling edge, check the current
  // outputs against the model, then let the rising edge advance the model.
  task automatic cyc(input bit st, input bit sl, input bit br, input int bi,
                     input bit we, input int wa, input int wd);
    int nxt;
    @(negedge clk);
    start = st; stall = sl; branch_taken = br; branch_idx = IDX_W'(bi);
    lut_we = we; lut_waddr = IDX_W'(wa); lut_wdata = PC_W'(wd);
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("instr", 32'(instr), 32'(imem[m_pc]));
    chk("instr_valid", 32'(instr_valid), 32'(m_mode == 1 && !sl));
    chk("done", 32'(done), 32'(m_mode == 2));
    @(posedge clk);
    nxt = m_pc;
    if (m_mode != 1) begin
      if (st) begin m_mode = 1; nxt = 0; end
    end else if (!sl) begin
      if (int'(imem[m_pc]) == HALT) m_mode = 2;
      else if (br)                  nxt = model_target(bi);
      else                          nxt = (m_pc + 1) % NPC;
    end
    m_pc = nxt;
    if (we) m_lut[wa] = wd % NPC;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset raised between edges must clear state without waiting for clk.
  task automatic mid_reset();
    @(negedge clk);
    start = 0; stall = 0; branch_taken = 0; lut_we = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_addr", 32'(imem_addr), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_valid", 32'(instr_valid), 32'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NPC; i++) imem[i] = '0;
    imem[12] = INSTR_W'(HALT);
    model_reset();

    #1;
    chk("por_pc", 32'(pc), 32'(0));
    chk("por_done", 32'(done), 32'(0));
    chk("por_valid", 32'(instr_valid), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    // start, then straight-line fetch 0,1,2,3
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle_cyc();
    // lut[3]=40 at pc 4, branch idx 3 at pc 5
    cyc(0, 0, 0, 0, 1, 3, 40);
    cyc(0, 0, 1, 3, 0, 0, 0);
    #2;
`ifndef RELATIVE_BRANCH_EN
    chk("branch_abs40", 32'(pc), 32'(40));
`endif
    // get to pc 7, stall 3 cycles with branch asserted, then release
    cyc(0, 0, 0, 0, 1, 4, 7);
    cyc(0, 0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 3, 0, 0, 0);
    cyc(0, 0, 1, 3, 0, 0, 0);
    // branch to the halt word at 12
    cyc(0, 0, 0, 0, 1, 5, 12);
    cyc(0, 0, 1, 5, 0, 0, 0);
    idle_cyc();
    idle_cyc();
    #2;
`ifndef RELATIVE_BRANCH_EN
    chk("halt_done", 32'(done), 32'(1));
    chk("halt_pc", 32'(pc), 32'(12));
`endif
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle_cyc();
    // branch to 20 and reset mid-cycle
    cyc(0, 0, 0, 0, 1, 6, 20);
    cyc(0, 0, 1, 6, 0, 0, 0);
    #2;
`ifndef RELATIVE_BRANCH_EN
    chk("pre_reset_pc", 32'(pc), 32'(20));
`endif
    mid_reset();
    idle_cyc();

    // Randomized phase with occasional halt words and resets.
    for (int i = 0; i < NPC; i++)
      imem[i] = ($urandom_range(0, 39) == 0) ? INSTR_W'(HALT) : INSTR_W'($urandom_range(0, HALT - 1));
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) mid_reset();
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0, int'($urandom_range(0, DEPTH - 1)),
          $urandom_range(0, 2) == 0, int'($urandom_range(0, DEPTH - 1)),
          int'($urandom_range(0, NPC - 1)));
    end
    idle_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
